pipo_bidirectional_shift_register: RTL and testbench

24-bit parallel-in/parallel-out register with parallel load, hold, logical right shift and logical left shift, selected per clock by a 2-bit mode.
- It sits in the floating-point adder datapath.
- Right shifts align the smaller operand's mantissa.
- Left shifts normalise the result.
- Bits shifted out on the right are tracked in registered guard/round/sticky flags for later rounding.

---
 rtl/pipo_pkg.sv | 64 ++++++
 rtl/pipo_grs_tracker.sv | 48 ++++
 rtl/pipo_bidirectional_shift_register.sv | 100 ++++++++++
 tb/tb_pipo_bidirectional_shift_register.sv | 139 +++++++++++++
 4 files changed

// File: rtl/pipo_pkg.sv
// -----------------------------------------------------------------------------
// pipo_pkg
//
// Shared definitions for the PIPO bidirectional shift register used in the
// floating-point adder datapath: the mode encoding seen on the S input, the
// default register width, and small helpers for the guard/round/sticky logic.
//
// Optional build macro used by the consumers of this package:
//   PIPO_ZERO_FLAG_EN - adds a registered "next A is zero" flag to the top.
// -----------------------------------------------------------------------------
package pipo_pkg;

    // Mantissa width including the hidden bit.
    localparam int PIPO_WIDTH = 24;

    // Per-cycle operation selected by S.
    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        LOAD = 2'b11
    } pipo_mode_e;

    // Guard/round/sticky bundle kept below A[0].
    typedef struct packed {
        logic guard;
        logic round;
        logic sticky;
    } pipo_grs_t;

    localparam pipo_grs_t PIPO_GRS_ZERO = '{guard: 1'b0, round: 1'b0, sticky: 1'b0};

    // Next guard/round/sticky state for a given mode. a_lsb is A[0] before
    // the update; it becomes the new guard on a right shift.
    function automatic pipo_grs_t pipo_grs_next(input pipo_mode_e mode,
                                                input pipo_grs_t  cur,
                                                input logic       a_lsb);
        pipo_grs_t nxt;
        nxt = cur;
        case (mode)
            SHR: begin
                nxt.guard  = a_lsb;
                nxt.round  = cur.guard;
                nxt.sticky = cur.sticky | cur.round;
            end
            SHL: begin
                // Guard moves up into A[0] (handled by the parent), round
                // moves up into guard, and a zero enters round. Sticky is
                // left alone: information already folded into it is lost.
                nxt.guard  = cur.round;
                nxt.round  = 1'b0;
                nxt.sticky = cur.sticky;
            end
            LOAD: begin
                nxt = PIPO_GRS_ZERO;
            end
            default: begin
                nxt = cur;
            end
        endcase
        return nxt;
    endfunction

endpackage : pipo_pkg

// File: rtl/pipo_grs_tracker.sv
// -----------------------------------------------------------------------------
// pipo_grs_tracker
//
// Holds the guard, round and sticky flops that sit below A[0] of the PIPO
// shift register, and applies their update rules for each mode.
//
// Ports:
//   Clk      in   clock, rising edge
//   Clear    in   synchronous active-high clear, zeroes all three flags
//   mode_i   in   current operation (pipo_mode_e)
//   a_lsb_i  in   A[0] before this edge, shifted into guard on SHR
//   guard_o  out  registered guard bit (first bit below A[0])
//   round_o  out  registered round bit (bit below guard)
//   sticky_o out  registered OR of everything shifted out below round
// -----------------------------------------------------------------------------
module pipo_grs_tracker
    import pipo_pkg::*;
(
    input  logic       Clk,
    input  logic       Clear,
    input  pipo_mode_e mode_i,
    input  logic       a_lsb_i,
    output logic       guard_o,
    output logic       round_o,
    output logic       sticky_o
);

    pipo_grs_t grs_q;
    pipo_grs_t grs_d;

    always_comb begin
        grs_d = grs_q;
        grs_d = pipo_grs_next(mode_i, grs_q, a_lsb_i);
    end

    always_ff @(posedge Clk) begin
        if (Clear) begin
            grs_q <= PIPO_GRS_ZERO;
        end else begin
            grs_q <= grs_d;
        end
    end

    assign guard_o  = grs_q.guard;
    assign round_o  = grs_q.round;
    assign sticky_o = grs_q.sticky;

endmodule : pipo_grs_tracker

// File: rtl/pipo_bidirectional_shift_register.sv
// -----------------------------------------------------------------------------
// pipo_bidirectional_shift_register
//
// Parallel-in/parallel-out mantissa register for the floating-point adder.
// Each clock it holds, loads, shifts right by one (operand alignment) or
// shifts left by one (result normalisation). Bits leaving on the right are
// tracked in registered guard/round/sticky flags for later rounding; a left
// shift pulls guard back into A[0], so SHR followed by SHL is lossless as
// long as nothing has reached sticky yet.
//
// Ports:
//   Clk     in   clock, all state updates on the rising edge
//   Clear   in   synchronous active-high clear, priority over S
//   I       in   [WIDTH-1:0] parallel load data
//   S       in   [1:0] mode: 00 hold, 01 shift right, 10 shift left, 11 load
//   A       out  [WIDTH-1:0] registered register contents
//   guard   out  registered bit just below A[0]
//   round   out  registered bit below guard
//   sticky  out  registered OR of bits shifted out below round
//   zero    out  (only with PIPO_ZERO_FLAG_EN) registered "A is all zero",
//                set to 1 by Clear
//
// Build macro: PIPO_ZERO_FLAG_EN enables the zero output.
// -----------------------------------------------------------------------------
module pipo_bidirectional_shift_register
    import pipo_pkg::*;
#(
    parameter int WIDTH = PIPO_WIDTH
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic [WIDTH-1:0] I,
    input  logic [1:0]       S,
    output logic [WIDTH-1:0] A,
    output logic             guard,
    output logic             round,
`ifdef PIPO_ZERO_FLAG_EN
    output logic             sticky,
    output logic             zero
`else
    output logic             sticky
`endif
);

    pipo_mode_e       mode;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic             guard_w;

    assign mode = pipo_mode_e'(S);

    // Mode mux for the main register. On SHL the vacated A[0] is refilled
    // from guard, and A[WIDTH-1] falls off the top.
    always_comb begin
        a_d = a_q;
        case (mode)
            SHR:     a_d = {1'b0, a_q[WIDTH-1:1]};
            SHL:     a_d = {a_q[WIDTH-2:0], guard_w};
            LOAD:    a_d = I;
            default: a_d = a_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clear) begin
            a_q <= '0;
        end else begin
            a_q <= a_d;
        end
    end

    pipo_grs_tracker u_grs (
        .Clk      (Clk),
        .Clear    (Clear),
        .mode_i   (mode),
        .a_lsb_i  (a_q[0]),
        .guard_o  (guard_w),
        .round_o  (round),
        .sticky_o (sticky)
    );

    assign A     = a_q;
    assign guard = guard_w;

`ifdef PIPO_ZERO_FLAG_EN
    // Computed from the next value of A so it is valid on the same edge.
    logic zero_q;

    always_ff @(posedge Clk) begin
        if (Clear) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= (a_d == '0);
        end
    end

    assign zero = zero_q;
`endif

endmodule : pipo_bidirectional_shift_register

// File: tb/tb_pipo_bidirectional_shift_register.sv
module tb_pipo_bidirectional_shift_register;
    import pipo_pkg::*;

    localparam int W = 24;

    logic         Clk;
    logic         Clear;
    logic [W-1:0] I;
    logic [1:0]   S;
    logic [W-1:0] A;
    logic         guard;
    logic         round;
    logic         sticky;
`ifdef PIPO_ZERO_FLAG_EN
    logic         zero;
`endif

    int passed = 0;
    int total  = 0;

    pipo_bidirectional_shift_register #(.WIDTH(W)) dut (
        .Clk    (Clk),
        .Clear  (Clear),
        .I      (I),
        .S      (S),
        .A      (A),
        .guard  (guard),
        .round  (round),
`ifdef PIPO_ZERO_FLAG_EN
        .sticky (sticky),
        .zero   (zero)
`else
        .sticky (sticky)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic clr, input logic [1:0] s, input logic [W-1:0] i);
        Clear = clr;
        S     = s;
        I     = i;
        @(posedge Clk);
        #1;
    endtask

    // Compares {A, guard, round, sticky} against the expected packed value.
    task automatic check(input string tag, input logic [W-1:0] ea, input logic [2:0] egrs);
        logic [W+2:0] obs;
        logic [W+2:0] exp;
        obs = {A, guard, round, sticky};
        exp = {ea, egrs};
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: A/grs observed %h/%b required %h/%b",
                    tag, obs[W+2:3], obs[2:0], exp[W+2:3], exp[2:0]);
    endtask

`ifdef PIPO_ZERO_FLAG_EN
    task automatic check_zero(input string tag, input logic ez);
        total++;
        assert (zero === ez) passed++;
        else $error("FAIL %s: zero observed %b required %b", tag, zero, ez);
    endtask
`endif

    initial begin
        Clear = 1'b1;
        S     = HOLD;
        I     = '0;
        #1;

        // Clear, then hold
        step(1'b1, HOLD, 24'h000000); check("clear",      24'h000000, 3'b000);
`ifdef PIPO_ZERO_FLAG_EN
        check_zero("zero_after_clear", 1'b1);
`endif
        step(1'b0, HOLD, 24'hABCDEF); check("hold0_a",    24'h000000, 3'b000);
        step(1'b0, HOLD, 24'h123456); check("hold0_b",    24'h000000, 3'b000);

        // Load 0x060002, SHR, SHR, HOLD, SHL
        step(1'b0, LOAD, 24'h060002); check("load_060002", 24'h060002, 3'b000);
        step(1'b0, SHR,  24'h000000); check("shr1",        24'h030001, 3'b000);
        step(1'b0, SHR,  24'h000000); check("shr2",        24'h018000, 3'b100);
        step(1'b0, HOLD, 24'hFFFFFF); check("hold_grs",    24'h018000, 3'b100);
        step(1'b0, SHL,  24'h000000); check("shl_restore", 24'h030001, 3'b000);

        // Load 7, shift out into guard/round/sticky
        step(1'b0, LOAD, 24'h000007); check("load_7",      24'h000007, 3'b000);
        step(1'b0, SHR,  24'h000000); check("7_shr1",      24'h000003, 3'b100);
        step(1'b0, SHR,  24'h000000); check("7_shr2",      24'h000001, 3'b110);
        step(1'b0, SHR,  24'h000000); check("7_shr3",      24'h000000, 3'b111);
        step(1'b0, SHR,  24'h000000); check("7_shr4",      24'h000000, 3'b011);
        step(1'b0, SHR,  24'h000000); check("7_shr5",      24'h000000, 3'b001);
        // SHL leaves sticky alone and does not wrap
        step(1'b0, SHL,  24'h000000); check("shl_sticky",  24'h000000, 3'b001);

        // Load clears sticky; multi-step alignment
        step(1'b0, LOAD, 24'h060080); check("load_060080", 24'h060080, 3'b000);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, SHR, 24'h000000);
        end
        check("shr5_060080", 24'h003004, 3'b000);

        // MSB lost on left shift, guard(0) fills A[0]
        step(1'b0, LOAD, 24'h800001); check("load_800001", 24'h800001, 3'b000);
        step(1'b0, SHL,  24'h000000); check("shl_msb",     24'h000002, 3'b000);

        // SHL moves round into guard and guard into A[0]
        step(1'b0, LOAD, 24'h000003);
        step(1'b0, SHR,  24'h000000);
        step(1'b0, SHR,  24'h000000); check("pre_shl_gr",  24'h000000, 3'b110);
        step(1'b0, SHL,  24'h000000); check("shl_gr",      24'h000001, 3'b100);

        // Clear beats a simultaneous load
        step(1'b0, LOAD, 24'h123456);
        step(1'b1, LOAD, 24'hFFFFFF); check("clear_vs_load", 24'h000000, 3'b000);
`ifdef PIPO_ZERO_FLAG_EN
        check_zero("zero_clear_vs_load", 1'b1);
        step(1'b0, LOAD, 24'h000001);
        check_zero("zero_after_load1", 1'b0);
        step(1'b0, SHR,  24'h000000);
        check_zero("zero_after_shr_to_0", 1'b1);
`endif

        // Clear in the middle of a shift sequence
        step(1'b0, LOAD, 24'h000007);
        step(1'b0, SHR,  24'h000000);
        step(1'b0, SHR,  24'h000000); check("mid_seq",     24'h000001, 3'b110);
        step(1'b1, SHR,  24'h000000); check("clear_mid",   24'h000000, 3'b000);
        step(1'b0, SHR,  24'h000000); check("after_clear", 24'h000000, 3'b000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_pipo_bidirectional_shift_register
